// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - sequential AES InvSubBytes engine
// One shared byte engine: inverse affine, then x^254 by square-and-multiply.
module inv_sub_bytes_seq #(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   in_state,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   out_state
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXP, DONE} state_t;

  state_t              state;
  logic [8*NBYTES-1:0] st;
  logic [IW-1:0]       idx;
  logic [2:0]          k;
  logic [7:0]          x;
  logic [7:0]          r;
  logic [7:0]          r_next;
  logic [7:0]          cur_byte;
  int                  pos;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    end
    return y ^ 8'h05;
  endfunction

  // Byte 0 sits in the most significant position of the state.
  always_comb begin
    pos      = (NBYTES - 1 - int'(idx)) * 8;
    cur_byte = st[pos +: 8];
    r_next   = gf_mul(gf_mul(r, r), (k != 3'd0) ? x : 8'h01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= '0;
      idx       <= '0;
      k         <= 3'd0;
      x         <= 8'h00;
      r         <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_state <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            st    <= in_state;
            idx   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          x     <= inv_affine(cur_byte);
          r     <= 8'h01;
          k     <= 3'd7;
          state <= EXP;
        end
        EXP: begin
          r <= r_next;
          // Exponent 0xFE: multiply on bits 7..1, plain square on bit 0.
          if (k == 3'd0) begin
            out_state[pos +: 8] <= r_next;
            if (idx == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= LOAD;
            end
          end else begin
            k <= k - 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - self-checking bench for inv_sub_bytes_seq
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] in_state;
  logic         busy;
  logic         done;
  logic [127:0] out_state;

  int checks = 0;
  int errors = 0;

  inv_sub_bytes_seq #(.NBYTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_state  (in_state),
    .busy      (busy),
    .done      (done),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] stim;
    logic [127:0] want;
    string        name;
  } vec_t;

  vec_t vecs[3];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] y;
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      y = 8'(c);
      if (gmul(a, y) == 8'h01) return y;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int j = 0; j < 16; j++) o[127 - 8*j -: 8] = inv_sbox(s[127 - 8*j -: 8]);
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [127:0] s, output logic [127:0] res,
                        output int lat, output int bc);
    @(negedge clk);
    in_state = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_state = ~s;
    lat = 0;
    bc  = 0;
    while (!done && lat < 1000) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (busy) bc++;
    res = out_state;
    @(negedge clk);
    chk("idle_after_done", {126'd0, busy, done}, 128'd0);
  endtask

  logic [127:0] res, s, e, a_st, b_st;
  int lat, bc, dcount;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_state = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    chk("reset_out", out_state, 128'd0);
    rst_n = 1'b1;

    vecs[0] = '{{16{8'h63}}, 128'h0, "all_63"};
    vecs[1] = '{128'h637c777bf26b6fc53001672bfed7ab76,
                128'h000102030405060708090a0b0c0d0e0f, "fips_seq"};
    vecs[2] = '{128'h00d416ed636363636363636363636363,
                128'h5219ff53000000000000000000000000, "mixed"};

    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i].stim, res, lat, bc);
      chk({vecs[i].name, "_out"}, res, vecs[i].want);
      chk({vecs[i].name, "_lat"}, 128'(lat), 128'd144);
      chk({vecs[i].name, "_busy"}, 128'(bc), 128'd145);
    end

    // Round trip through the forward S-box for every byte value.
    for (int op = 0; op < 16; op++) begin
      for (int j = 0; j < 16; j++) begin
        s[127 - 8*j -: 8] = fwd_sbox(8'(op*16 + j));
        e[127 - 8*j -: 8] = 8'(op*16 + j);
      end
      run_op(s, res, lat, bc);
      chk($sformatf("roundtrip_%0d", op), res, e);
    end

    for (int t = 0; t < 8; t++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run_op(s, res, lat, bc);
      chk($sformatf("random_%0d", t), res, model(s));
    end

    // start held high; in_state changes mid-operation.
    a_st = {$urandom, $urandom, $urandom, $urandom};
    b_st = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_state = a_st;
    start    = 1'b1;
    @(negedge clk);
    in_state = b_st;
    lat = 0;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_lat", 128'(lat), 128'd144);
    chk("hold_out_first", out_state, model(a_st));
    @(negedge clk);
    chk("hold_idle_gap", {126'd0, busy, done}, 128'd0);
    @(negedge clk);
    chk("hold_restart", {127'd0, busy}, 128'd1);
    start    = 1'b0;
    in_state = a_st;
    lat = 0;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("hold2_lat", 128'(lat), 128'd144);
    chk("hold2_out", out_state, model(b_st));
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    in_state = '0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    chk("pre_reset_partial", out_state[127:120], 128'h52);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {127'd0, busy}, 128'd0);
    chk("async_done", {127'd0, done}, 128'd0);
    chk("async_out", out_state, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("no_done_after_reset", 128'(dcount), 128'd0);
    chk("out_held_zero", out_state, 128'd0);
    run_op(vecs[1].stim, res, lat, bc);
    chk("post_reset_out", res, vecs[1].want);
    chk("post_reset_lat", 128'(lat), 128'd144);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
